// File: rtl/digit_pkg.sv
// Shared definitions for the digit bounding-box scanner: default image size,
// result record and scanner state encoding.
package digit_pkg;

    localparam int IMG_WIDTH  = 28;
    localparam int IMG_HEIGHT = 28;

    // Index fields sized for the largest supported image (64 x 64).
    localparam int BBOX_IDX_W = 6;

    typedef struct packed {
        logic [BBOX_IDX_W-1:0] top;
        logic [BBOX_IDX_W-1:0] bottom;
        logic [BBOX_IDX_W-1:0] left;
        logic [BBOX_IDX_W-1:0] right;
        logic                  empty;
    } bbox_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_COLSCAN,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/digit_bbox_scanner_if.sv
// Start/Done handshake, frame-buffer row port and bounding-box result bundle.
interface digit_bbox_scanner_if
    import digit_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic             start;
    logic             abort;
    logic             row_rd;
    logic [RW-1:0]    row_addr;
    logic [WIDTH-1:0] row_data;
    logic             busy;
    logic             done;
    logic             empty;
    logic [RW-1:0]    top;
    logic [RW-1:0]    bottom;
    logic [CW-1:0]    left;
    logic [CW-1:0]    right;

    modport master (
        output start, abort, row_data,
        input  row_rd, row_addr, busy, done, empty, top, bottom, left, right
    );

    modport slave (
        input  start, abort, row_data,
        output row_rd, row_addr, busy, done, empty, top, bottom, left, right
    );

endinterface

// File: rtl/row_or_reduce.sv
// Normalises a bitmap row so that 1 means ink, and flags whether the row has any ink.
module row_or_reduce #(
    parameter int               WIDTH       = 28,
    parameter logic [WIDTH-1:0] INVERT_MASK = '0
) (
    input  logic [WIDTH-1:0] row,
    output logic [WIDTH-1:0] pix,
    output logic             any
);

    assign pix = row ^ INVERT_MASK;
    assign any = |pix;

endmodule

// File: rtl/digit_bbox_scanner.sv
// Row-serial bounding-box extractor for the binarized digit bitmap.
// Define BBOX_ACTIVE_LOW_PIXELS_EN when the frame buffer stores ink as 0.
module digit_bbox_scanner
    import digit_pkg::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT
) (
    input  logic clock,
    input  logic reset_n,
    digit_bbox_scanner_if.slave bus
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [RW-1:0] LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
`ifdef BBOX_ACTIVE_LOW_PIXELS_EN
    localparam logic [WIDTH-1:0] INV_MASK = '1;
`else
    localparam logic [WIDTH-1:0] INV_MASK = '0;
`endif

    scan_state_t      state, state_nxt;
    logic [RW-1:0]    row_cnt, row_idx;
    logic             row_pend;
    logic [CW-1:0]    col_cnt;
    logic [WIDTH-1:0] col_acc, pix;
    logic             row_any, row_found, col_found;
    logic [RW-1:0]    wk_top, wk_bottom, top_q, bottom_q;
    logic [CW-1:0]    wk_left, wk_right, left_q, right_q;
    logic [CW-1:0]    left_nxt, right_nxt;
    logic             empty_q, consume, col_hit, last_col, accept;

    row_or_reduce #(.WIDTH(WIDTH), .INVERT_MASK(INV_MASK)) u_reduce (
        .row (bus.row_data),
        .pix (pix),
        .any (row_any)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.start) state_nxt = S_READ;
                S_READ:    if (row_cnt == LAST_ROW) state_nxt = S_DRAIN;
                S_DRAIN:   state_nxt = S_COLSCAN;
                S_COLSCAN: if (last_col) state_nxt = S_DONE;
                S_DONE:    state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy   = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        bus.row_rd = (state == S_READ) && !bus.abort;
    end

    // Row data returns one cycle after its read strobe, so the index travels with it.
    assign accept    = (state == S_IDLE) && bus.start && !bus.abort;
    assign consume   = row_pend && ((state == S_READ) || (state == S_DRAIN));
    assign col_hit   = col_acc[col_cnt];
    assign last_col  = (col_cnt == LAST_COL);
    assign left_nxt  = (col_hit && !col_found) ? col_cnt : wk_left;
    assign right_nxt = col_hit ? col_cnt : wk_right;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            row_cnt   <= '0;
            row_idx   <= '0;
            row_pend  <= 1'b0;
            col_cnt   <= '0;
            col_acc   <= '0;
            row_found <= 1'b0;
            col_found <= 1'b0;
            wk_top    <= '0;
            wk_bottom <= '0;
            wk_left   <= '0;
            wk_right  <= '0;
            top_q     <= '0;
            bottom_q  <= '0;
            left_q    <= '0;
            right_q   <= '0;
            empty_q   <= 1'b1;
        end else begin
            row_pend <= bus.row_rd;
            row_idx  <= row_cnt;
            if (accept) begin
                row_cnt   <= '0;
                col_acc   <= '0;
                row_found <= 1'b0;
                col_found <= 1'b0;
                wk_top    <= '0;
                wk_bottom <= '0;
                wk_left   <= '0;
                wk_right  <= '0;
            end
            if ((state == S_READ) && (row_cnt != LAST_ROW)) row_cnt <= row_cnt + 1'b1;
            if (consume) begin
                col_acc <= col_acc | pix;
                if (row_any) begin
                    if (!row_found) wk_top <= row_idx;
                    row_found <= 1'b1;
                    wk_bottom <= row_idx;
                end
            end
            if (state == S_DRAIN) col_cnt <= '0;
            if (state == S_COLSCAN) begin
                if (!last_col) col_cnt <= col_cnt + 1'b1;
                if (col_hit) col_found <= 1'b1;
                wk_left  <= left_nxt;
                wk_right <= right_nxt;
                // Results are committed on entry to DONE so they are valid with the Done pulse.
                if (last_col && !bus.abort) begin
                    empty_q  <= !row_found;
                    top_q    <= row_found ? wk_top    : '0;
                    bottom_q <= row_found ? wk_bottom : '0;
                    left_q   <= row_found ? left_nxt  : '0;
                    right_q  <= row_found ? right_nxt : '0;
                end
            end
        end
    end

    assign bus.row_addr = row_cnt;
    assign bus.empty    = empty_q;
    assign bus.top      = top_q;
    assign bus.bottom   = bottom_q;
    assign bus.left     = left_q;
    assign bus.right    = right_q;

endmodule

// File: tb/tb_digit_bbox_scanner.sv
// Self-checking bench for digit_bbox_scanner against a frame-level bounding-box model.
module tb_digit_bbox_scanner;
    import digit_pkg::*;

    localparam int W   = IMG_WIDTH;
    localparam int H   = IMG_HEIGHT;
    localparam int RWB = $clog2(H);
    localparam int LAT = H + W + 2;
`ifdef BBOX_ACTIVE_LOW_PIXELS_EN
    localparam logic [W-1:0] PIX_MASK = '1;
`else
    localparam logic [W-1:0] PIX_MASK = '0;
`endif

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    digit_bbox_scanner_if #(.WIDTH(W), .HEIGHT(H)) bus ();
    digit_bbox_scanner #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [W-1:0] ink [H];
    int checks = 0;
    int errors = 0;

    // Frame buffer: data for the strobed address one cycle later, junk otherwise.
    always @(posedge clock)
        bus.row_data <= bus.row_rd ? (ink[bus.row_addr] ^ PIX_MASK) : W'($urandom);

    function automatic bbox_t model();
        bbox_t b;
        logic [W-1:0] cols;
        bit found;
        b = '0; cols = '0; found = 0;
        for (int r = 0; r < H; r++) begin
            cols = cols | ink[r];
            if (ink[r] != '0) begin
                if (!found) b.top = 6'(r);
                b.bottom = 6'(r);
                found = 1;
            end
        end
        b.empty = !found;
        if (found) begin
            for (int c = W - 1; c >= 0; c--) if (cols[c]) b.left = 6'(c);
            for (int c = 0; c < W; c++)      if (cols[c]) b.right = 6'(c);
        end
        return b;
    endfunction

    function automatic bbox_t observed();
        bbox_t b;
        b.top = 6'(bus.top); b.bottom = 6'(bus.bottom);
        b.left = 6'(bus.left); b.right = 6'(bus.right); b.empty = bus.empty;
        return b;
    endfunction

    function automatic bbox_t mk(int t, int bo, int l, int ri, bit e);
        bbox_t b;
        b.top = 6'(t); b.bottom = 6'(bo); b.left = 6'(l); b.right = 6'(ri); b.empty = e;
        return b;
    endfunction

    task automatic clear_frame();
        for (int r = 0; r < H; r++) ink[r] = '0;
    endtask

    // Drives Start from a falling edge and follows the scan until Done or a cycle budget.
    task automatic do_scan(output int lat, output int rd_cnt, output int addr_err);
        lat = 0; rd_cnt = 0; addr_err = 0;
        bus.start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
            if (bus.row_rd === 1'b1) begin
                if (bus.row_addr !== rd_cnt[RWB-1:0]) addr_err++;
                if (n != rd_cnt + 1) addr_err++;
                rd_cnt++;
            end
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bbox_t got;
        reset_n = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
        clear_frame();
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checks++;
        if ({bus.busy, bus.done, bus.row_rd} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000", {bus.busy, bus.done, bus.row_rd});
        end
        checks++;
        if (bus.row_addr !== '0) begin
            errors++; $display("FAIL reset_addr got %0d exp 0", bus.row_addr);
        end
        got = observed();
        checks++;
        if (got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL reset_bbox got %0d/%0d/%0d/%0d e%0b exp 0/0/0/0 e1",
                               got.top, got.bottom, got.left, got.right, got.empty);
        end
    endtask

    task automatic test_empty();
        int lat, rd, ae;
        bbox_t got;
        clear_frame();
        do_scan(lat, rd, ae);
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL empty_latency got %0d exp %0d", lat, LAT); end
        checks++;
        if (rd !== H) begin errors++; $display("FAIL empty_rd_count got %0d exp %0d", rd, H); end
        checks++;
        if (ae !== 0) begin errors++; $display("FAIL empty_addr_seq got %0d exp 0", ae); end
        got = observed();
        checks++;
        if (got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL empty_bbox got %0d/%0d/%0d/%0d e%0b exp 0/0/0/0 e1",
                               got.top, got.bottom, got.left, got.right, got.empty);
        end
        @(negedge clock);
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++; $display("FAIL done_pulse got %b exp 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_single();
        int lat, rd, ae;
        bbox_t got;
        clear_frame(); ink[5][9] = 1'b1;
        do_scan(lat, rd, ae);
        got = observed();
        checks++;
        if (lat !== LAT || got !== mk(5, 5, 9, 9, 0)) begin
            errors++; $display("FAIL single_5_9 got %0d/%0d/%0d/%0d e%0b lat %0d exp 5/5/9/9 e0 lat %0d",
                               got.top, got.bottom, got.left, got.right, got.empty, lat, LAT);
        end
        @(negedge clock);
        clear_frame(); ink[3][7] = 1'b1;
        do_scan(lat, rd, ae);
        got = observed();
        checks++;
        if (got !== mk(3, 3, 7, 7, 0)) begin
            errors++; $display("FAIL single_3_7 got %0d/%0d/%0d/%0d e%0b exp 3/3/7/7 e0",
                               got.top, got.bottom, got.left, got.right, got.empty);
        end
    endtask

    task automatic test_corners();
        int lat, rd, ae;
        bbox_t got;
        @(negedge clock);
        clear_frame(); ink[0][0] = 1'b1; ink[H-1][W-1] = 1'b1;
        do_scan(lat, rd, ae);
        got = observed();
        checks++;
        if (got !== mk(0, H - 1, 0, W - 1, 0)) begin
            errors++; $display("FAIL corners got %0d/%0d/%0d/%0d e%0b exp 0/%0d/0/%0d e0",
                               got.top, got.bottom, got.left, got.right, got.empty, H - 1, W - 1);
        end
    endtask

    task automatic test_back_to_back();
        int lat, rd, ae;
        bbox_t got;
        @(negedge clock);
        clear_frame();
        for (int r = 4; r <= 20; r++) ink[r][13] = 1'b1;
        do_scan(lat, rd, ae);
        got = observed();
        checks++;
        if (got !== mk(4, 20, 13, 13, 0)) begin
            errors++; $display("FAIL b2b_first got %0d/%0d/%0d/%0d e%0b exp 4/20/13/13 e0",
                               got.top, got.bottom, got.left, got.right, got.empty);
        end
        clear_frame(); ink[10][2] = 1'b1;
        @(negedge clock);
        do_scan(lat, rd, ae);
        got = observed();
        checks++;
        if (lat !== LAT || got !== mk(10, 10, 2, 2, 0)) begin
            errors++; $display("FAIL b2b_second got %0d/%0d/%0d/%0d e%0b lat %0d exp 10/10/2/2 e0 lat %0d",
                               got.top, got.bottom, got.left, got.right, got.empty, lat, LAT);
        end
    endtask

    task automatic test_start_in_done();
        int lat, rd, ae;
        @(negedge clock);
        do_scan(lat, rd, ae);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_in_done got busy %b exp 0", bus.busy); end
    endtask

    task automatic test_abort_reset();
        int lat, rd, ae, done_seen;
        bbox_t got, prior;
        clear_frame(); ink[7][3] = 1'b1;
        do_scan(lat, rd, ae);
        prior = model();
        @(negedge clock);
        clear_frame(); ink[15][20] = 1'b1;
        bus.start = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        bus.abort = 1'b1;
        @(negedge clock);
        bus.abort = 1'b0;
        checks++;
        if ({bus.busy, bus.row_rd, bus.done} !== 3'b000) begin
            errors++; $display("FAIL abort_idle got %b exp 000", {bus.busy, bus.row_rd, bus.done});
        end
        done_seen = 0;
        repeat (LAT + 5) begin @(negedge clock); if (bus.done === 1'b1) done_seen++; end
        got = observed();
        checks++;
        if (done_seen !== 0 || got !== prior) begin
            errors++; $display("FAIL abort_hold got %0d/%0d/%0d/%0d e%0b done %0d exp %0d/%0d/%0d/%0d e%0b done 0",
                               got.top, got.bottom, got.left, got.right, got.empty, done_seen,
                               prior.top, prior.bottom, prior.left, prior.right, prior.empty);
        end
        bus.start = 1'b1; bus.abort = 1'b1;
        @(negedge clock);
        bus.start = 1'b0; bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL start_abort_idle got busy %b exp 0", bus.busy); end
        bus.start = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        got = observed();
        checks++;
        if ({bus.busy, bus.row_rd, bus.done} !== 3'b000 || bus.row_addr !== '0 || got !== mk(0, 0, 0, 0, 1)) begin
            errors++; $display("FAIL reset_midscan got ctrl %b addr %0d bbox %0d/%0d/%0d/%0d e%0b exp 000 0 0/0/0/0 e1",
                               {bus.busy, bus.row_rd, bus.done}, bus.row_addr,
                               got.top, got.bottom, got.left, got.right, got.empty);
        end
        @(negedge clock);
        reset_n = 1'b1;
        done_seen = 0;
        repeat (LAT + 5) begin @(negedge clock); if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++; end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL reset_no_done got %0d exp 0", done_seen); end
    endtask

    task automatic test_random();
        int lat, rd, ae, mode, r0, r1, c0, c1;
        bbox_t got, exp_b;
        for (int it = 0; it < 10; it++) begin
            clear_frame();
            mode = $urandom_range(0, 3);
            case (mode)
                1: ink[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 1'b1;
                2: for (int r = 0; r < H; r++)
                       if ($urandom_range(0, 3) == 0) ink[r] = W'($urandom & $urandom & $urandom);
                3: begin
                       r0 = $urandom_range(0, H - 1); r1 = $urandom_range(r0, H - 1);
                       c0 = $urandom_range(0, W - 1); c1 = $urandom_range(c0, W - 1);
                       for (int r = r0; r <= r1; r++)
                           for (int c = c0; c <= c1; c++) ink[r][c] = 1'b1;
                   end
                default: ;
            endcase
            exp_b = model();
            @(negedge clock);
            do_scan(lat, rd, ae);
            got = observed();
            checks++;
            if (lat !== LAT || rd !== H || ae !== 0 || got !== exp_b) begin
                errors++; $display("FAIL random_%0d got %0d/%0d/%0d/%0d e%0b lat %0d rd %0d ae %0d exp %0d/%0d/%0d/%0d e%0b lat %0d rd %0d ae 0",
                                   it, got.top, got.bottom, got.left, got.right, got.empty, lat, rd, ae,
                                   exp_b.top, exp_b.bottom, exp_b.left, exp_b.right, exp_b.empty, LAT, H);
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_single();
        test_corners();
        test_back_to_back();
        test_start_in_done();
        test_abort_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_bbox_scanner.md
# digit_bbox_scanner

Sequential bounding-box extractor for the binarized input digit bitmap, placed between the pixel frame buffer and the downscale/normalize stage. It reads the bitmap one row per cycle, reduces each row with a wide OR to find occupied rows, and accumulates a column-occupancy vector. It then scans that vector to find occupied columns. It reports the tight bounding box (Top, Bottom, Left, Right) or an Empty flag through a Start/Done handshake.

## Interface
- WIDTH, 28, pixels per row (bits of Row_Data), 2..64
- HEIGHT, 28, rows per frame, 2..64
- CW, $clog2(WIDTH), column index width
- RW, $clog2(HEIGHT), row index width
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin scan; sampled only in IDLE
- Abort  in  1  synchronous cancel; returns to IDLE
- Row_Rd  out  1  row read strobe to frame buffer
- Row_Addr  out  RW  row address, valid with Row_Rd
- Row_Data  in  WIDTH  row pixels; bit c = column c; valid exactly 1 cycle after Row_Rd
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse; results valid
- Empty  out  1  no set pixel in last completed frame
- Top, Bottom  out  RW  first/last occupied row
- Left, Right  out  CW  first/last occupied column

## Operation
- States: IDLE, READ, DRAIN, COLSCAN, DONE.
- IDLE: if Start, clear the row-found flag and the column accumulator col_acc[WIDTH-1:0], go to READ with row counter 0.
- READ: Row_Rd=1 and Row_Addr=counter. The counter increments each cycle. After address HEIGHT-1 is issued, go to DRAIN.
- Data handling, in READ cycles after the first and in DRAIN, for the returned row k:
  - row_or = OR-reduction of Row_Data.
  - col_acc |= Row_Data.
  - If row_or and no row found yet: Top=k, set found.
  - If row_or: Bottom=k.
- DRAIN: Row_Rd=0. Consumes the last row, then goes to COLSCAN with column counter 0.
- COLSCAN: one column per cycle, 0..WIDTH-1. The first set col_acc bit gives Left; every set bit updates Right. After column WIDTH-1, go to DONE.
- DONE: Done=1 for one cycle. Empty = !found. If empty, force Top=Bottom=Left=Right=0. Then go to IDLE.
- Results hold until the next DONE; they are not disturbed during a scan.
- Abort in any non-IDLE state: IDLE next cycle, no Done, result outputs keep their previous values, Row_Rd deasserts immediately.
- Start while Busy is ignored. Start and Abort together in IDLE: Abort wins and the block stays in IDLE.
- Start asserted in the DONE cycle is ignored; the caller re-asserts it in IDLE.

## Timing
- Reset values: state IDLE; Busy=0, Done=0, Row_Rd=0, Row_Addr=0, Empty=1, Top=Bottom=Left=Right=0; internal counters and col_acc are 0.
- Cycle numbering: Start is sampled at edge 0.
- Row_Rd is high for cycles 1..HEIGHT.
- Rows are consumed in cycles 2..HEIGHT+1; DRAIN is cycle HEIGHT+1.
- COLSCAN occupies cycles HEIGHT+2..HEIGHT+WIDTH+1.
- Done is high in cycle HEIGHT+WIDTH+2: 58 cycles after Start for the 28×28 default.
- Busy is high from cycle 1 through the Done cycle inclusive.
- Back-to-back operation: next Start is accepted at the earliest 1 cycle after Done.
- Reset_n asserted mid-scan: all outputs return to reset values asynchronously. A partial frame is never reported.

## Configuration
- BBOX_ACTIVE_LOW_PIXELS_EN defined: every Row_Data bit is inverted before the OR-reduction and the col_acc update, so a 0 pixel counts as ink (frame buffer stores ink as 0).
- Macro undefined: a 1 pixel counts as ink; no inversion.
- Timing is identical in both builds.

## Structure
- Shared package digit_pkg holds:
  - IMG_WIDTH=28 and IMG_HEIGHT=28
  - the bbox_t struct {top, bottom, left, right, empty}
  - the scanner state enum
- One sub-module, row_or_reduce:
  - parameters WIDTH and INVERT_MASK (all-ones when BBOX_ACTIVE_LOW_PIXELS_EN is defined, zero otherwise)
  - outputs the inverted-as-needed row and its OR-reduction
- The FSM, counters and col_acc stay in digit_bbox_scanner.

## Test plan
- All-zero frame, Start -> Done at cycle 58, Empty=1, Top=Bottom=Left=Right=0.
- Single pixel at row 5, column 9 -> Top=Bottom=5, Left=Right=9, Empty=0.
- Pixels at (0,0) and (27,27) -> Top=0, Bottom=27, Left=0, Right=27; verifies the boundary rows and columns.
- Vertical stroke, rows 4..20, column 13, then Start re-asserted 1 cycle after Done with a new frame holding a pixel at (10,2) -> first result 4/20/13/13; second result 10/10/2/2 with no stale state.
- Abort at cycle 20, then a reset pulse at cycle 10 of a second scan -> no Done, Row_Rd low the next cycle, results unchanged after Abort and at reset values after Reset_n.
- Build with BBOX_ACTIVE_LOW_PIXELS_EN, all-ones frame except a 0 at (3,7) -> Top=Bottom=3, Left=Right=7.
